// File: rtl/fsm_share_sched.sv
// Time-shares one serial-input Moore FSM among N_REQ requesters: grant, reset FSM, stream pattern LSB first, collect outputs.
// Define FSM_SCHED_RR_EN for round-robin arbitration; otherwise the lowest asserted index wins.
module fsm_share_sched #(
    parameter int N_REQ = 4,
    parameter int PAT_W = 8
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*PAT_W-1:0]     pat_data,
    output logic [N_REQ-1:0]           grant,
    output logic                       fsm_rst,
    output logic                       fsm_in,
    input  logic                       fsm_out,
    output logic                       res_valid,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic [PAT_W-1:0]           res_data,
    output logic                       busy
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(PAT_W + 1);
    localparam logic [CW-1:0] KLAST = CW'(PAT_W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, FRST, SHIFT, DRAIN, DONE} state_t;
    state_t state, nxt;

    logic [CW-1:0]    k, k_d;
    logic [PAT_W-1:0] pat, pat_d, acc, acc_d, acc_in;
    logic [N_REQ-1:0] grant_d;
    logic             fsm_rst_d, fsm_in_d, res_valid_d, busy_d;
    logic [IDW-1:0]   res_id_d, win;
    logic [PAT_W-1:0] res_data_d;
    logic             any_req;

    assign any_req = |req;
    // New FSM output enters at the top; after PAT_W samples the first lands in bit 0.
    assign acc_in  = (acc >> 1) | (PAT_W'(fsm_out) << (PAT_W - 1));

`ifdef FSM_SCHED_RR_EN
    logic [IDW-1:0] ptr;

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v % N_REQ);
    endfunction

    // Descending scan so the index closest to ptr is assigned last and wins.
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[wrap(int'(ptr) + i)]) win = wrap(int'(ptr) + i);
    end

    always_ff @(posedge clk) begin
        if (areset)
            ptr <= '0;
        else if (state == IDLE && any_req)
            ptr <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
`else
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[i]) win = IDW'(i);
    end
`endif

    always_ff @(posedge clk) begin
        if (areset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (any_req) nxt = LOAD;
            LOAD:    nxt = FRST;
            FRST:    nxt = SHIFT;
            SHIFT:   if (k == KLAST) nxt = DRAIN;
            DRAIN:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Register inputs are derived from the next state so every output is a flop.
    always_comb begin
        grant_d     = grant;
        fsm_rst_d   = (nxt == FRST);
        fsm_in_d    = 1'b0;
        res_valid_d = (nxt == DONE);
        busy_d      = (nxt != IDLE);
        res_id_d    = res_id;
        res_data_d  = res_data;
        k_d         = k;
        pat_d       = pat;
        acc_d       = acc;
        case (state)
            IDLE: if (any_req) begin
                grant_d  = N_REQ'(1) << win;
                res_id_d = win;
                pat_d    = pat_data[int'(win)*PAT_W +: PAT_W];
            end
            FRST: begin
                fsm_in_d = pat[0];
                pat_d    = pat >> 1;
                k_d      = '0;
            end
            SHIFT: begin
                fsm_in_d = (k == KLAST) ? 1'b0 : pat[0];
                pat_d    = pat >> 1;
                if (k != '0)    acc_d = acc_in;
                if (k != KLAST) k_d   = k + 1'b1;
            end
            DRAIN: begin
                acc_d      = acc_in;
                res_data_d = acc_in;
                grant_d    = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            grant     <= '0;
            fsm_rst   <= 1'b0;
            fsm_in    <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            k         <= '0;
            pat       <= '0;
            acc       <= '0;
        end else begin
            grant     <= grant_d;
            fsm_rst   <= fsm_rst_d;
            fsm_in    <= fsm_in_d;
            res_valid <= res_valid_d;
            busy      <= busy_d;
            res_id    <= res_id_d;
            res_data  <= res_data_d;
            k         <= k_d;
            pat       <= pat_d;
            acc       <= acc_d;
        end
    end
endmodule

// File: tb/tb_fsm_share_sched.sv
// Bench for fsm_share_sched: toggle-FSM stand-in, job-timeline reference model, per-cycle compare plus literal checks.
module tb_fsm_share_sched;
    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 0, areset = 1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   pat_data = '0;
    logic [N-1:0]     grant;
    logic             fsm_rst, fsm_in, fsm_out, res_valid, busy;
    logic [1:0]       res_id;
    logic [W-1:0]     res_data;

    fsm_share_sched #(.N_REQ(N), .PAT_W(W)) dut (
        .clk(clk), .areset(areset), .req(req), .pat_data(pat_data),
        .grant(grant), .fsm_rst(fsm_rst), .fsm_in(fsm_in), .fsm_out(fsm_out),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy));

    always #5 clk = ~clk;

    // Shared FSM stand-in: reset state outputs 1, in=0 toggles, in=1 holds.
    logic fsm_q = 1'b0;
    assign fsm_out = fsm_q;
    always @(posedge clk)
        if (fsm_rst)      fsm_q <= 1'b1;
        else if (!fsm_in) fsm_q <= ~fsm_q;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int arb(input logic [N-1:0] r, input int p);
`ifdef FSM_SCHED_RR_EN
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
`else
        for (int i = 0; i < N; i++) if (r[i]) return i;
`endif
        return 0;
    endfunction

    // Result bit k = FSM output after bits 0..k: starts at 1, flips on every zero bit.
    function automatic logic [W-1:0] res_of(input logic [W-1:0] p);
        logic s = 1'b1;
        logic [W-1:0] r = '0;
        for (int i = 0; i < W; i++) begin
            if (!p[i]) s = ~s;
            r[i] = s;
        end
        return r;
    endfunction

    // Job timeline model: offset d from the accepting IDLE cycle determines every output.
    int cyc = 0, m_t0 = 0, m_win = 0, m_id = 0, m_ptr = 0;
    logic m_act = 1'b0;
    logic [W-1:0] m_pat = '0, m_data = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (areset) begin
            m_act <= 1'b0; m_id <= 0; m_data <= '0; m_ptr <= 0;
        end else if (!m_act) begin
            if (req != '0) begin
                m_act <= 1'b1;
                m_t0  <= cyc;
                m_win <= arb(req, m_ptr);
                m_id  <= arb(req, m_ptr);
                m_pat <= pat_data[arb(req, m_ptr)*W +: W];
                m_ptr <= (arb(req, m_ptr) + 1) % N;
            end
        end else begin
            if (cyc - m_t0 == 3 + W) m_data <= res_of(m_pat);
            if (cyc - m_t0 == 4 + W) m_act  <= 1'b0;
        end
    end

    logic chk_en = 1'b0;
    initial begin : cmp
        int d;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                d = cyc - m_t0;
                chk("grant", grant, (m_act && d >= 1 && d <= 3 + W) ? (1 << m_win) : 0);
                chk("fsm_rst", fsm_rst, (m_act && d == 2) ? 1 : 0);
                chk("fsm_in", fsm_in, (m_act && d >= 3 && d <= 2 + W) ? m_pat[d-3] : 0);
                chk("res_valid", res_valid, (m_act && d == 4 + W) ? 1 : 0);
                chk("busy", busy, (m_act && d >= 1 && d <= 4 + W) ? 1 : 0);
                chk("res_id", res_id, m_id);
                chk("res_data", res_data, m_data);
            end
        end
    end

    typedef struct { int c; int id; int data; } rec_t;
    rec_t res_q[$];
    int   rst_q[$];
    initial forever begin
        @(negedge clk);
        if (res_valid) res_q.push_back('{cyc, int'(res_id), int'(res_data)});
        if (fsm_rst)   rst_q.push_back(cyc);
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_res(input int n, input int budget);
        int b = 0;
        while (res_q.size() < n && b < budget) begin step(); b++; end
        if (res_q.size() < n) chk("res_timeout", res_q.size(), n);
    endtask

    int t0, cd;
    int exp_ids[5];
    initial begin
`ifdef FSM_SCHED_RR_EN
        exp_ids = '{0, 1, 2, 3, 0};
`else
        exp_ids = '{0, 0, 0, 0, 0};
`endif
        repeat (3) step();
        areset = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_res_data", res_data, 0);
        step();

        // Single job, all-zero pattern on requester 0.
        res_q.delete(); rst_q.delete();
        req = 4'b0001; pat_data = '0; t0 = cyc;
        step(); req = '0;
        wait_res(1, 40);
        chk("t1_latency", res_q[0].c - t0, 12);
        chk("t1_id", res_q[0].id, 0);
        chk("t1_data", res_q[0].data, 8'hAA);
        chk("t1_rst_count", rst_q.size(), 1);
        chk("t1_rst_cycle", rst_q[0] - t0, 2);
        step();

        // All-ones on requester 2, then 8'h35 on requester 1.
        res_q.delete();
        pat_data = {8'h00, 8'hFF, 8'h35, 8'h00};
        req = 4'b0100; step(); req = '0;
        wait_res(1, 40);
        chk("t2_id", res_q[0].id, 2);
        chk("t2_data", res_q[0].data, 8'hFF);
        step();
        req = 4'b0010; step(); req = '0;
        wait_res(2, 40);
        chk("t2b_id", res_q[1].id, 1);
        chk("t2b_data", res_q[1].data, 8'hB9);
        step();

        // req dropped mid-SHIFT; new req during DONE waits for the following IDLE.
        res_q.delete();
        pat_data = {8'hA5, 8'h00, 8'h35, 8'h00};
        req = 4'b1000; t0 = cyc;
        while (cyc < t0 + 5) step();
        req = '0;
        wait_res(1, 40);
        chk("t3_id", res_q[0].id, 3);
        chk("t3_data", res_q[0].data, 8'hC9);
        cd = res_q[0].c;
        req = 4'b0010;
        step();
        chk("t3_idle_grant", grant, 0);
        chk("t3_idle_cycle", cyc - cd, 1);
        step();
        chk("t3_load_grant", grant, 4'b0010);
        req = '0;
        wait_res(2, 40);
        chk("t3b_id", res_q[1].id, 1);
        step();

        // Reset during SHIFT k=3 aborts the job.
        res_q.delete();
        pat_data = {8'h00, 8'h0F, 8'h00, 8'h00};
        req = 4'b0001; t0 = cyc;
        step(); req = '0;
        while (cyc < t0 + 6) step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_grant", grant, 0);
        chk("t4_fsm_in", fsm_in, 0);
        chk("t4_res_data", res_data, 0);
        repeat (20) step();
        chk("t4_no_result", res_q.size(), 0);
        req = 4'b0100; step(); req = '0;
        wait_res(1, 40);
        chk("t4_id", res_q[0].id, 2);
        chk("t4_data", res_q[0].data, 8'hAF);
        step();

        // Arbitration with all requests held, pointer freshly reset.
        areset = 1'b1; step(); step(); areset = 1'b0;
        res_q.delete();
        pat_data = 32'h12345678;
        req = 4'b1111;
        wait_res(5, 100);
        req = '0;
        for (int i = 0; i < 5; i++) chk($sformatf("t5_order%0d", i), res_q[i].id, exp_ids[i]);
        step();

        // Back-to-back jobs from one held request.
        res_q.delete();
        req = 4'b0100;
        wait_res(3, 60);
        req = '0;
        chk("t6_gap1", res_q[1].c - res_q[0].c, 13);
        chk("t6_gap2", res_q[2].c - res_q[1].c, 13);
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
